// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, sync marker and error codes for the UART loader
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR0 = 3'd1,
    ADDR1 = 3'd2,
    LEN0  = 3'd3,
    LEN1  = 3'd4,
    DATA  = 3'd5,
    CHK   = 3'd6
  } state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHK      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;
endpackage

// File: rtl/uart_loader_if.sv
// uart_loader_if: byte input, memory write port and CPU/status lines of the loader
interface uart_loader_if #(parameter int ADDR_WIDTH = 16);
  logic [7:0]            in_data;
  logic                  in_data_valid;
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic [31:0]           out_mem_data;
  logic                  out_mem_we;
  logic                  in_mem_ready;
  logic                  out_cpu_reset;
  logic                  out_done;
  logic                  out_error;
  logic [1:0]            out_error_code;
  modport master (
    input  in_data, in_data_valid, in_mem_ready,
    output out_mem_addr, out_mem_data, out_mem_we, out_cpu_reset, out_done, out_error, out_error_code
  );
  modport slave (
    output in_data, in_data_valid, in_mem_ready,
    input  out_mem_addr, out_mem_data, out_mem_we, out_cpu_reset, out_done, out_error, out_error_code
  );
endinterface

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: shifts bytes LSB-first into a 32-bit word and flags the 4th byte
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done
);
  logic [23:0] sr;
  logic [1:0]  idx;
  assign word      = {din, sr};
  assign word_done = en && idx == 2'd3;
  // shift register and byte index; clr parks the index at 0 outside the data phase
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr  <= '0;
      idx <= '0;
    end else if (clr) begin
      sr  <= '0;
      idx <= '0;
    end else if (en) begin
      sr  <= {din, sr[23:8]};
      idx <= idx + 2'd1;
    end
endmodule

// File: rtl/uart_loader.sv
// uart_loader: parses framed UART load packets and writes 32-bit words to CPU memory
module uart_loader
  import uart_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input logic           clk,
  input logic           rst,
  uart_loader_if.master bus
);
  localparam int TW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t        state;
  logic [7:0]    addr_lo, len_lo, chk;
  logic [15:0]   words;
  logic [TW-1:0] idle_cnt;
  logic [31:0]   word;
  logic          word_done, strobe, overrun, accept, timeout;
  assign strobe  = bus.in_data_valid;
  assign accept  = bus.out_mem_we && bus.in_mem_ready;
  assign overrun = strobe && bus.out_mem_we && !bus.in_mem_ready;
  assign timeout = state != IDLE && !strobe && idle_cnt == TW'(TIMEOUT_CYCLES - 2);
  byte_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (state != DATA),
    .en        (strobe && state == DATA && !overrun),
    .din       (bus.in_data),
    .word      (word),
    .word_done (word_done)
  );
  // frame FSM with checksum, inter-byte timeout and memory write handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state              <= IDLE;
      addr_lo            <= '0;
      len_lo             <= '0;
      chk                <= '0;
      words              <= '0;
      idle_cnt           <= '0;
      bus.out_mem_addr   <= '0;
      bus.out_mem_data   <= '0;
      bus.out_mem_we     <= 1'b0;
      bus.out_cpu_reset  <= 1'b0;
      bus.out_done       <= 1'b0;
      bus.out_error      <= 1'b0;
      bus.out_error_code <= ERR_NONE;
    end else begin
      bus.out_done  <= 1'b0;
      bus.out_error <= 1'b0;
      idle_cnt      <= (state == IDLE || strobe) ? '0 : idle_cnt + 1'b1;
      if (accept) begin
        bus.out_mem_we   <= 1'b0;
        bus.out_mem_addr <= bus.out_mem_addr + 1'b1;
      end
      if (overrun || timeout) begin
        state              <= IDLE;
        chk                <= '0;
        bus.out_mem_we     <= 1'b0;
        bus.out_cpu_reset  <= 1'b0;
        bus.out_error      <= 1'b1;
        bus.out_error_code <= overrun ? ERR_OVERRUN : ERR_TIMEOUT;
      end else if (strobe) begin
        if (state inside {ADDR0, ADDR1, LEN0, LEN1, DATA}) chk <= chk + bus.in_data;
        case (state)
          IDLE: begin
            chk <= '0;
            if (bus.in_data == SYNC_BYTE) begin
              state             <= ADDR0;
              bus.out_cpu_reset <= 1'b1;
            end
          end
          ADDR0: begin
            addr_lo <= bus.in_data;
            state   <= ADDR1;
          end
          ADDR1: begin
            bus.out_mem_addr <= ADDR_WIDTH'({bus.in_data, addr_lo});
            state            <= LEN0;
          end
          LEN0: begin
            len_lo <= bus.in_data;
            state  <= LEN1;
          end
          LEN1: begin
            words <= {bus.in_data, len_lo};
            state <= {bus.in_data, len_lo} == 16'd0 ? CHK : DATA;
          end
          DATA: if (word_done) begin
            bus.out_mem_data <= word;
            bus.out_mem_we   <= 1'b1;
            words            <= words - 16'd1;
            if (words == 16'd1) state <= CHK;
          end
          CHK: begin
            state             <= IDLE;
            bus.out_cpu_reset <= 1'b0;
            if (chk == bus.in_data) bus.out_done <= 1'b1;
            else begin
              bus.out_error      <= 1'b1;
              bus.out_error_code <= ERR_CHK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: table-driven frames plus hand sequences for overrun, timeout and reset
module tb_uart_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_loader_if #(.ADDR_WIDTH(16)) bus ();
  uart_loader #(.ADDR_WIDTH(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  typedef struct {
    logic [0:15][7:0] b;
    int               n;
    int               nw;
    logic [15:0]      a0, a1;
    logic [31:0]      d0, d1;
    int               done;
    int               err;
    logic [1:0]       code;
  } vec_t;
  vec_t v [4];
  int n_chk = 0, n_fail = 0, n_done = 0, n_err = 0, nw = 0;
  logic [15:0] wa [8];
  logic [31:0] wd [8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // capture accepted writes and status pulses between clock edges
  always @(negedge clk) begin
    if (bus.out_mem_we && bus.in_mem_ready && nw < 8) begin
      wa[nw] = bus.out_mem_addr;
      wd[nw] = bus.out_mem_data;
      nw++;
    end
    if (bus.out_done) n_done++;
    if (bus.out_error) n_err++;
    if (bus.out_done || bus.out_error) check("done_error_exclusive", {31'd0, bus.out_done & bus.out_error}, 32'd0);
  end
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.in_data       = b;
    bus.in_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_data_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask
  task automatic send_seq(input logic [7:0] q [$]);
    foreach (q[k]) send_byte(q[k]);
  endtask
  task automatic clear_obs();
    nw = 0;
    n_done = 0;
    n_err = 0;
  endtask
  task automatic run_vec(input int i);
    clear_obs();
    for (int k = 0; k < v[i].n; k++) begin
      send_byte(v[i].b[k]);
      if (k == v[i].n - 2) check($sformatf("v%0d_cpu_reset_in_frame", i), {31'd0, bus.out_cpu_reset}, 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("v%0d_write_count", i), nw, v[i].nw);
    if (v[i].nw > 0) begin
      check($sformatf("v%0d_addr0", i), {16'd0, wa[0]}, {16'd0, v[i].a0});
      check($sformatf("v%0d_data0", i), wd[0], v[i].d0);
    end
    if (v[i].nw > 1) begin
      check($sformatf("v%0d_addr1", i), {16'd0, wa[1]}, {16'd0, v[i].a1});
      check($sformatf("v%0d_data1", i), wd[1], v[i].d1);
    end
    check($sformatf("v%0d_done_pulses", i), n_done, v[i].done);
    check($sformatf("v%0d_error_pulses", i), n_err, v[i].err);
    check($sformatf("v%0d_error_code", i), {30'd0, bus.out_error_code}, {30'd0, v[i].code});
    check($sformatf("v%0d_cpu_reset_after", i), {31'd0, bus.out_cpu_reset}, 32'd0);
  endtask
  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, {16'd0, bus.out_mem_addr}, 32'd0);
    check({tag, "_data"}, bus.out_mem_data, 32'd0);
    check({tag, "_ctrl"}, {27'd0, bus.out_mem_we, bus.out_cpu_reset, bus.out_done, bus.out_error, 1'b0}, 32'd0);
    check({tag, "_code"}, {30'd0, bus.out_error_code}, 32'd0);
  endtask
  initial begin
    bus.in_data       = 8'h00;
    bus.in_data_valid = 1'b0;
    bus.in_mem_ready  = 1'b1;
    v[0] = '{b: {8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h76, 16'h0},
             n: 14, nw: 2, a0: 16'h0010, a1: 16'h0011, d0: 32'h44332211, d1: 32'h88776655, done: 1, err: 0, code: 2'd0};
    v[1] = '{b: {8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 16'h0},
             n: 14, nw: 2, a0: 16'h0010, a1: 16'h0011, d0: 32'h44332211, d1: 32'h88776655, done: 0, err: 1, code: 2'd1};
    v[2] = '{b: {8'h00, 8'hFF, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFE, 64'h0},
             n: 8, nw: 0, a0: 16'h0, a1: 16'h0, d0: 32'h0, d1: 32'h0, done: 1, err: 0, code: 2'd1};
    v[3] = '{b: {8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24, 16'h0},
             n: 14, nw: 2, a0: 16'hFFFF, a1: 16'h0000, d0: 32'h04030201, d1: 32'h08070605, done: 1, err: 0, code: 2'd1};
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("after_reset");
    for (int i = 0; i < 4; i++) run_vec(i);
    // overrun: write held by a stalled memory when the checksum byte arrives
    clear_obs();
    bus.in_mem_ready = 1'b0;
    send_seq('{8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    #1;
    check("ovr_we_held", {31'd0, bus.out_mem_we}, 32'd1);
    check("ovr_addr", {16'd0, bus.out_mem_addr}, 32'h0100);
    check("ovr_data", bus.out_mem_data, 32'hDDCCBBAA);
    send_byte(8'h55);
    #1;
    check("ovr_error_pulses", n_err, 1);
    check("ovr_code", {30'd0, bus.out_error_code}, 32'd3);
    check("ovr_we_dropped", {31'd0, bus.out_mem_we}, 32'd0);
    check("ovr_cpu_reset", {31'd0, bus.out_cpu_reset}, 32'd0);
    check("ovr_no_write", nw, 0);
    check("ovr_no_done", n_done, 0);
    // recovery frame after the overrun
    clear_obs();
    bus.in_mem_ready = 1'b1;
    send_seq('{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h2B});
    repeat (2) @(posedge clk);
    #1;
    check("rec_writes", nw, 1);
    check("rec_addr", {16'd0, wa[0]}, 32'h0020);
    check("rec_data", wd[0], 32'h04030201);
    check("rec_done", n_done, 1);
    check("rec_error", n_err, 0);
    // memory becomes ready in the same cycle as the next byte: no overrun
    clear_obs();
    bus.in_mem_ready = 1'b0;
    send_seq('{8'hA5, 8'h30, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    @(posedge clk); #1;
    bus.in_data       = 8'h3B;
    bus.in_data_valid = 1'b1;
    bus.in_mem_ready  = 1'b1;
    @(posedge clk); #1;
    bus.in_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("same_cycle_writes", nw, 1);
    check("same_cycle_addr", {16'd0, wa[0]}, 32'h0030);
    check("same_cycle_done", n_done, 1);
    check("same_cycle_error", n_err, 0);
    // timeout: sync byte then silence
    clear_obs();
    @(posedge clk); #1;
    bus.in_data       = 8'hA5;
    bus.in_data_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_data_valid = 1'b0;
    for (int k = 1; k <= 99; k++) begin
      @(posedge clk); #1;
      if (k == 98) begin
        check("to_no_error_at_98", {31'd0, bus.out_error}, 32'd0);
        check("to_cpu_reset_at_98", {31'd0, bus.out_cpu_reset}, 32'd1);
      end
      if (k == 99) begin
        check("to_error_at_99", {31'd0, bus.out_error}, 32'd1);
        check("to_code", {30'd0, bus.out_error_code}, 32'd2);
        check("to_cpu_reset_low", {31'd0, bus.out_cpu_reset}, 32'd0);
      end
    end
    @(posedge clk); #1;
    check("to_error_width", n_err, 1);
    // asynchronous reset in the middle of the data phase
    clear_obs();
    send_seq('{8'hA5, 8'h00, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    check("mid_first_write", nw, 1);
    check("mid_cpu_reset_before", {31'd0, bus.out_cpu_reset}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    #4;
    rst = 1'b0;
    run_vec(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
